// File: rtl/tdm_pkg.sv
// Shared TDM helpers: frame-length arithmetic, counter widths and the slot-bit to
// sample-bit mapping used by both the transmit framer and the future receive deframer.
package tdm_pkg;

  function automatic int tdm_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int tdm_frame_bclk(input int num_ch, input int slot_w);
    return num_ch * slot_w;
  endfunction

  function automatic int tdm_frame_mclk(input int num_ch, input int slot_w, input int mclk_div);
    return tdm_frame_bclk(num_ch, slot_w) * mclk_div;
  endfunction

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int tdm_cnt_w(input int n);
    return (n > 1) ? tdm_clog2(n) : 1;
  endfunction

  // Bit of the packed sample vector carried by frame bit bit_idx, or -1 for slot padding.
  function automatic int tdm_slot_src(input int bit_idx, input int slot_w, input int sample_w);
    int pos;
    pos = bit_idx % slot_w;
    if (pos >= sample_w) return -1;
    return (bit_idx / slot_w) * sample_w + (sample_w - 1 - pos);
  endfunction

endpackage

// File: rtl/tdm_frame_timer.sv
// Free-running frame counter producing registered bclk/wclk/frame_start (one mclk behind cnt)
// plus combinational load (cnt==0), bit_edge (phase 0) and bit index strobes. No backpressure.
module tdm_frame_timer
  import tdm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SLOT_W   = 32,
  parameter int MCLK_DIV = 2,
  localparam int FRAME_MCLK = tdm_frame_mclk(NUM_CH, SLOT_W, MCLK_DIV),
  localparam int CNT_W      = tdm_cnt_w(FRAME_MCLK),
  localparam int PH_W       = tdm_clog2(MCLK_DIV),
  localparam int BIT_W      = CNT_W - PH_W
) (
  input  logic             mclk,
  input  logic             rst_n,
  output logic             bclk,
  output logic             wclk,
  output logic             frame_start,
  output logic             load,
  output logic             bit_edge,
  output logic [BIT_W-1:0] bit_idx
);

  logic [CNT_W-1:0] cnt;
  logic [PH_W-1:0]  phase;

  assign phase    = cnt[PH_W-1:0];
  assign bit_idx  = cnt[CNT_W-1:PH_W];
  assign load     = (cnt == '0);
  assign bit_edge = (phase == '0);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      bclk        <= 1'b0;
      wclk        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= (cnt == CNT_W'(FRAME_MCLK - 1)) ? '0 : cnt + 1'b1;
      // MCLK_DIV is a power of two, so phase >= MCLK_DIV/2 is just the phase MSB.
      bclk        <= phase[PH_W-1];
      wclk        <= (bit_idx == '0);
      frame_start <= load;
    end
  end

endmodule

// File: rtl/tdm_tx_framer.sv
// TDM transmitter: one-frame holding buffer (din_ready = buffer empty), frames load at cnt==0 and
// shift out MSB-first one mclk after the counter. TDM_TX_REPEAT_ON_UNDERRUN_EN repeats the last frame on underrun.
module tdm_tx_framer
  import tdm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int MCLK_DIV = 2
) (
  input  logic                       mclk,
  input  logic                       rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0] din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       bclk,
  output logic                       wclk,
  output logic                       tdm_out,
  output logic                       frame_start,
  output logic                       underrun,
  input  logic                       underrun_clr
);

  localparam int DIN_W      = NUM_CH * SAMPLE_W;
  localparam int FRAME_BCLK = tdm_frame_bclk(NUM_CH, SLOT_W);
  localparam int BIT_W      = tdm_cnt_w(tdm_frame_mclk(NUM_CH, SLOT_W, MCLK_DIV)) - tdm_clog2(MCLK_DIV);

  logic                  load;
  logic                  bit_edge;
  logic [BIT_W-1:0]      bit_idx;
  logic [DIN_W-1:0]      hold_q;
  logic                  hold_full;
  logic                  armed;
  logic                  accept;
  logic [FRAME_BCLK-1:0] shift_q;
  logic [FRAME_BCLK-1:0] frame_fmt;
  logic [FRAME_BCLK-1:0] frame_next;

  tdm_frame_timer #(
    .NUM_CH   (NUM_CH),
    .SLOT_W   (SLOT_W),
    .MCLK_DIV (MCLK_DIV)
  ) u_timer (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .bclk        (bclk),
    .wclk        (wclk),
    .frame_start (frame_start),
    .load        (load),
    .bit_edge    (bit_edge),
    .bit_idx     (bit_idx)
  );

  // Frame bit b is what goes on the wire during bit index b.
  for (genvar b = 0; b < FRAME_BCLK; b++) begin : g_map
    localparam int SRC = tdm_slot_src(b, SLOT_W, SAMPLE_W);
    if (SRC >= 0) begin : g_dat
      assign frame_fmt[b] = hold_q[SRC];
    end else begin : g_pad
      assign frame_fmt[b] = 1'b0;
    end
  end

`ifdef TDM_TX_REPEAT_ON_UNDERRUN_EN
  assign frame_next = hold_full ? frame_fmt : shift_q;
`else
  assign frame_next = hold_full ? frame_fmt : '0;
`endif

  assign din_ready = ~hold_full;
  assign accept    = din_valid & ~hold_full;

  // An accept coinciding with an empty-buffer load fills hold for the next frame only.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_q    <= din;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      tdm_out  <= 1'b0;
      armed    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (load) begin
        shift_q <= frame_next;
        tdm_out <= frame_next[0];
        if (hold_full) armed <= 1'b1;
      end else if (bit_edge) begin
        tdm_out <= shift_q[bit_idx];
      end
      if (underrun_clr)
        underrun <= 1'b0;
      else if (load && !hold_full && armed)
        underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdm_tx_framer.sv
// Directed bench: default 4x16/32 instance plus an 8x24/32, MCLK_DIV=4 instance.
// Outputs are sampled on mclk falling edges; k below is the counter value those samples reflect.
module tb_tdm_tx_framer;

`ifdef TDM_TX_REPEAT_ON_UNDERRUN_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic         mclk;
  logic         rst_n, rst8_n;
  logic [63:0]  din;
  logic         din_valid, din_ready, bclk, wclk, tdm_out, frame_start, underrun, underrun_clr;
  logic [191:0] din8;
  logic         din_valid8, din_ready8, bclk8, wclk8, tdm8, fs8, underrun8, underrun_clr8;

  int errors = 0;
  int checks = 0;
  logic [127:0] fr;
  logic [255:0] f8;
  logic [63:0]  single_dat, last_dat;
  logic [63:0]  sd [3];

  tdm_tx_framer dut (
    .mclk(mclk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .bclk(bclk), .wclk(wclk), .tdm_out(tdm_out), .frame_start(frame_start),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  tdm_tx_framer #(.NUM_CH(8), .SAMPLE_W(24), .SLOT_W(32), .MCLK_DIV(4)) dut8 (
    .mclk(mclk), .rst_n(rst8_n), .din(din8), .din_valid(din_valid8), .din_ready(din_ready8),
    .bclk(bclk8), .wclk(wclk8), .tdm_out(tdm8), .frame_start(fs8),
    .underrun(underrun8), .underrun_clr(underrun_clr8)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  function automatic logic [127:0] exp_frame(input logic [63:0] d);
    logic [127:0] f;
    f = '0;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 16; j++)
        f[c*32 + j] = d[c*16 + 15 - j];
    return f;
  endfunction

  // Starts at the frame_start sample, ends at the next frame's frame_start sample.
  task automatic capture(output logic [127:0] f);
    f = '0;
    for (int k = 0; k < 256; k++) begin
      if (k % 2 == 1) f[k/2] = tdm_out;
      @(negedge mclk);
    end
  endtask

  task automatic capture8(output logic [255:0] f);
    f = '0;
    for (int k = 0; k < 1024; k++) begin
      if (k % 4 == 3) f[k/4] = tdm8;
      @(negedge mclk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge mclk);
    checks++; if ({bclk, wclk, tdm_out, frame_start, underrun} !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b want 00000", {bclk, wclk, tdm_out, frame_start, underrun}); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", din_ready); end
    rst_n = 1'b1;
    @(negedge mclk);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_fs: got %b want 1", frame_start); end
  endtask

  task automatic test_idle;
    int fs_bad, fs_cnt, bad_b, bad_w, ones, urn;
    fs_bad = 0; fs_cnt = 0; bad_b = 0; bad_w = 0; ones = 0; urn = 0;
    for (int k = 0; k < 512; k++) begin
      if (frame_start !== ((k % 256) == 0)) fs_bad++;
      if (frame_start === 1'b1) fs_cnt++;
      if (bclk !== ((k % 2) == 1)) bad_b++;
      if (wclk !== ((k % 256) < 2)) bad_w++;
      if (tdm_out !== 1'b0) ones++;
      if (underrun !== 1'b0) urn++;
      @(negedge mclk);
    end
    checks++; if (fs_bad != 0 || fs_cnt != 2) begin errors++; $display("FAIL idle_fs_period: bad=%0d pulses=%0d want 0/2", fs_bad, fs_cnt); end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL idle_bclk: %0d bad samples want 0", bad_b); end
    checks++; if (bad_w != 0) begin errors++; $display("FAIL idle_wclk: %0d bad samples want 0", bad_w); end
    checks++; if (ones != 0) begin errors++; $display("FAIL idle_tdm_out: %0d ones want 0", ones); end
    checks++; if (urn != 0) begin errors++; $display("FAIL idle_underrun: %0d set samples want 0", urn); end
  endtask

  task automatic test_single_frame;
    single_dat = {16'h0000, 16'hA5A5, 16'h7FFE, 16'h8001};
    repeat (10) @(negedge mclk);
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL single_ready_pre: got %b want 1", din_ready); end
    din = single_dat; din_valid = 1'b1;
    @(negedge mclk);
    din_valid = 1'b0; din = 64'hDEAD_BEEF_CAFE_F00D;
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %b want 0", din_ready); end
    repeat (244) @(negedge mclk);
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL single_ready_hold: got %b want 0", din_ready); end
    @(negedge mclk);
    checks++; if (frame_start !== 1'b1 || din_ready !== 1'b1) begin errors++; $display("FAIL single_load: fs=%b ready=%b want 1/1", frame_start, din_ready); end
    checks++; if (wclk !== 1'b1 || tdm_out !== 1'b1) begin errors++; $display("FAIL single_msb_with_wclk: wclk=%b tdm=%b want 1/1", wclk, tdm_out); end
    capture(fr);
    checks++; if (fr[31:0] !== 32'h0000_8001) begin errors++; $display("FAIL slot0: got %h want 00008001", fr[31:0]); end
    checks++; if (fr[95:64] !== 32'h0000_A5A5) begin errors++; $display("FAIL slot2: got %h want 0000a5a5", fr[95:64]); end
    checks++; if (fr !== 128'h0000_0000_0000_A5A5_0000_7FFE_0000_8001) begin errors++; $display("FAIL single_frame: got %h", fr); end
    last_dat = single_dat;
  endtask

  task automatic test_underrun;
    logic [127:0] e;
    e = REPEAT ? exp_frame(last_dat) : '0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b want 1", underrun); end
    capture(fr);
    checks++; if (fr !== e) begin errors++; $display("FAIL underrun_frame: got %h want %h", fr, e); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
    repeat (255) @(negedge mclk);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky_late: got %b want 1", underrun); end
    underrun_clr = 1'b1;
    @(negedge mclk);
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clr_priority: got %b want 0", underrun); end
    repeat (10) @(negedge mclk);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clr_holds: got %b want 0", underrun); end
  endtask

  task automatic test_back_to_back;
    int accepts, stalls, bad;
    sd[0] = {16'h8000, 16'h00FF, 16'hC001, 16'h1234};
    sd[1] = {16'h0F0F, 16'h5555, 16'h0000, 16'hFFFF};
    sd[2] = {16'h0001, 16'h8421, 16'hFF00, 16'h3C5A};
    accepts = 0; stalls = 0; bad = 0;
    fork
      begin
        int j;
        logic rdy;
        j = 0; din = sd[0]; din_valid = 1'b1;
        for (int n = 0; n < 3000 && j < 3; n++) begin
          rdy = din_ready;
          @(negedge mclk);
          if (rdy) begin
            accepts++; j++;
            if (j < 3) din = sd[j]; else din_valid = 1'b0;
          end else stalls++;
        end
        din_valid = 1'b0;
      end
      begin
        logic [127:0] f;
        for (int n = 0; n < 300 && frame_start !== 1'b1; n++) @(negedge mclk);
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL stream_wait_fs: timeout"); end
        for (int i = 0; i < 3; i++) begin
          if (underrun !== 1'b0) bad++;
          capture(f);
          checks++; if (f !== exp_frame(sd[i])) begin errors++; $display("FAIL stream_frame%0d: got %h want %h", i, f, exp_frame(sd[i])); end
        end
      end
    join
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_underrun: %0d set want 0", bad); end
    checks++; if (accepts != 3) begin errors++; $display("FAIL stream_accepts: got %0d want 3", accepts); end
    checks++; if (stalls != 500) begin errors++; $display("FAIL stream_stalls: got %0d want 500", stalls); end
    last_dat = sd[2];
  endtask

  task automatic test_accept_at_boundary;
    logic [63:0] d;
    logic [127:0] e;
    d = {16'h1357, 16'h2468, 16'hFACE, 16'h0C0D};
    e = REPEAT ? exp_frame(last_dat) : '0;
    underrun_clr = 1'b1;
    @(negedge mclk);
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL bnd_clr: got %b want 0", underrun); end
    repeat (254) @(negedge mclk);
    din = d; din_valid = 1'b1;
    @(negedge mclk);
    din_valid = 1'b0;
    checks++; if (underrun !== 1'b1 || din_ready !== 1'b0) begin errors++; $display("FAIL bnd_accept: underrun=%b ready=%b want 1/0", underrun, din_ready); end
    capture(fr);
    checks++; if (fr !== e) begin errors++; $display("FAIL bnd_cur_frame: got %h want %h", fr, e); end
    checks++; if (din_ready !== 1'b1 || underrun !== 1'b1) begin errors++; $display("FAIL bnd_next_load: ready=%b underrun=%b want 1/1", din_ready, underrun); end
    capture(fr);
    checks++; if (fr !== exp_frame(d)) begin errors++; $display("FAIL bnd_next_frame: got %h want %h", fr, exp_frame(d)); end
  endtask

  task automatic test_8ch;
    logic [191:0] p;
    int gap_bad;
    p = {24'h000001, {6{24'h000000}}, 24'h800000};
    checks++; if ({bclk8, wclk8, tdm8, fs8, underrun8, din_ready8} !== 6'b000001) begin errors++; $display("FAIL w8_reset: got %b want 000001", {bclk8, wclk8, tdm8, fs8, underrun8, din_ready8}); end
    rst8_n = 1'b1;
    @(negedge mclk);
    checks++; if (fs8 !== 1'b1) begin errors++; $display("FAIL w8_first_fs: got %b want 1", fs8); end
    gap_bad = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k > 0 && fs8 !== 1'b0) gap_bad++;
      if (k == 20) begin din8 = p; din_valid8 = 1'b1; end
      else din_valid8 = 1'b0;
      @(negedge mclk);
    end
    checks++; if (fs8 !== 1'b1 || gap_bad != 0) begin errors++; $display("FAIL w8_frame_len: fs=%b early=%0d want 1/0", fs8, gap_bad); end
    capture8(f8);
    checks++; if (f8[0] !== 1'b1 || f8[247] !== 1'b1 || f8[231] !== 1'b0) begin errors++; $display("FAIL w8_bits: b0=%b b247=%b b231=%b want 1/1/0", f8[0], f8[247], f8[231]); end
    checks++; if ($countones(f8) != 2) begin errors++; $display("FAIL w8_ones: got %0d want 2", $countones(f8)); end
    checks++; if (underrun8 !== 1'b1) begin errors++; $display("FAIL w8_underrun: got %b want 1", underrun8); end
    for (int k = 0; k < 1024; k++) begin
      din_valid8 = (k == 20);
      @(negedge mclk);
    end
    repeat (990) @(negedge mclk);
    checks++; if (bclk8 !== 1'b1 || tdm8 !== 1'b1 || underrun8 !== 1'b1) begin errors++; $display("FAIL w8_pre_reset: bclk=%b tdm=%b urn=%b want 1/1/1", bclk8, tdm8, underrun8); end
    #1 rst8_n = 1'b0;
    #1;
    checks++; if ({bclk8, wclk8, tdm8, fs8, underrun8, din_ready8} !== 6'b000001) begin errors++; $display("FAIL w8_async_reset: got %b want 000001", {bclk8, wclk8, tdm8, fs8, underrun8, din_ready8}); end
  endtask

  initial begin
    rst_n = 1'b0; rst8_n = 1'b0;
    din = '0; din_valid = 1'b0; underrun_clr = 1'b0;
    din8 = '0; din_valid8 = 1'b0; underrun_clr8 = 1'b0;
    single_dat = '0; last_dat = '0;
    test_reset();
    test_idle();
    test_single_frame();
    test_underrun();
    test_back_to_back();
    test_accept_at_boundary();
    test_8ch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
